// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO controller and its memory.
package fifo_pkg;

  // Occupancy update selected each cycle by the counter logic.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } cnt_op_e;

  // Pointer width: enough bits to address every slot, at least one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Count width: must represent 0 through depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // No reset: contents are only meaningful between the pointers.
  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock valid/ready FIFO with occupancy count, watermark flags and synchronous flush.
// Optional zero-latency empty bypass enabled by defining SYNC_FIFO_CTRL_BYPASS_EN.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_SIZE       = 4,
  parameter int ALMOST_FULL_TH  = FIFO_SIZE - 1,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                           clk_i,
  input  logic                           arst_i,
  input  logic                           clear_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic                           data_in_valid_i,
  output logic                           data_in_ready_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           data_out_valid_o,
  input  logic                           data_out_ready_i,
  output logic [$clog2(FIFO_SIZE+1)-1:0] count_o,
  output logic                           almost_full_o,
  output logic                           almost_empty_o
);

  localparam int PTR_W = ptr_width(FIFO_SIZE);
  localparam int CNT_W = cnt_width(FIFO_SIZE);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_SIZE);

  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg,  count_next;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  stored_valid;
  logic                  bypass_hit;
  logic                  bypass_take;
  logic                  push, pop;
  logic                  wr_en, rd_en;
  cnt_op_e               cnt_op;

  // Wrap by compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_SIZE  (FIFO_SIZE),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_reg),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_reg),
    .rdata_o (mem_rdata)
  );

  // Readiness depends only on registered count, never on the same-cycle pop.
  assign data_in_ready_o = (count_reg != FULL_CNT) & ~clear_i;
  assign stored_valid    = (count_reg != '0) & ~clear_i;

`ifdef SYNC_FIFO_CTRL_BYPASS_EN
  assign bypass_hit       = (count_reg == '0) & data_in_valid_i & ~clear_i;
  assign data_out_valid_o = stored_valid | bypass_hit;
  assign data_o           = bypass_hit ? data_i : mem_rdata;
`else
  assign bypass_hit       = 1'b0;
  assign data_out_valid_o = stored_valid;
  assign data_o           = mem_rdata;
`endif

  assign push        = data_in_valid_i & data_in_ready_o;
  assign pop         = data_out_valid_o & data_out_ready_i;
  // A bypassed word consumed in the same cycle never touches storage.
  assign bypass_take = bypass_hit & data_out_ready_i;
  assign wr_en       = push & ~bypass_take;
  assign rd_en       = pop & ~bypass_take;

  always_comb begin
    cnt_op = HOLD;
    if (wr_en && !rd_en) begin
      cnt_op = INC;
    end else if (rd_en && !wr_en) begin
      cnt_op = DEC;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clear_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_next = ptr_adv(wr_ptr_reg);
      end
      if (rd_en) begin
        rd_ptr_next = ptr_adv(rd_ptr_reg);
      end
      unique case (cnt_op)
        INC:     count_next = count_reg + 1'b1;
        DEC:     count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign count_o        = count_reg;
  assign almost_full_o  = int'(count_reg) >= ALMOST_FULL_TH;
  assign almost_empty_o = int'(count_reg) <= ALMOST_EMPTY_TH;

`ifdef SIMULATION
  initial begin
    if (FIFO_SIZE < 2)
      $warning("sync_fifo_ctrl: FIFO_SIZE=%0d is below 2", FIFO_SIZE);
    if (ALMOST_FULL_TH > FIFO_SIZE)
      $warning("sync_fifo_ctrl: ALMOST_FULL_TH=%0d exceeds FIFO_SIZE", ALMOST_FULL_TH);
    if (ALMOST_EMPTY_TH >= FIFO_SIZE)
      $warning("sync_fifo_ctrl: ALMOST_EMPTY_TH=%0d not below FIFO_SIZE", ALMOST_EMPTY_TH);
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: queue-based reference model plus directed and random traffic.
module tb_sync_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF_TH = DEPTH - 1;
  localparam int AE_TH = 1;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          clear_i;
  logic [DW-1:0] data_i;
  logic          data_in_valid_i;
  logic          data_in_ready_o;
  logic [DW-1:0] data_o;
  logic          data_out_valid_o;
  logic          data_out_ready_i;
  logic [2:0]    count_o;
  logic          almost_full_o;
  logic          almost_empty_o;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] model [$];

  always #5 clk_i = ~clk_i;

  sync_fifo_ctrl #(
    .DATA_WIDTH      (DW),
    .FIFO_SIZE       (DEPTH),
    .ALMOST_FULL_TH  (AF_TH),
    .ALMOST_EMPTY_TH (AE_TH)
  ) dut (
    .clk_i            (clk_i),
    .arst_i           (arst_i),
    .clear_i          (clear_i),
    .data_i           (data_i),
    .data_in_valid_i  (data_in_valid_i),
    .data_in_ready_o  (data_in_ready_o),
    .data_o           (data_o),
    .data_out_valid_o (data_out_valid_o),
    .data_out_ready_i (data_out_ready_i),
    .count_o          (count_o),
    .almost_full_o    (almost_full_o),
    .almost_empty_o   (almost_empty_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived from queue occupancy and current inputs.
  task automatic expect_outs(output logic e_valid, output logic [DW-1:0] e_data);
    int   n;
    logic e_ready;
    n       = model.size();
    e_ready = (n != DEPTH) && !clear_i;
    e_valid = (n != 0) && !clear_i;
    e_data  = (n != 0) ? model[0] : data_i;
`ifdef SYNC_FIFO_CTRL_BYPASS_EN
    if (n == 0 && data_in_valid_i && !clear_i) e_valid = 1'b1;
`endif
    check("count", 32'(count_o), 32'(n));
    check("in_ready", 32'(data_in_ready_o), 32'(e_ready));
    check("out_valid", 32'(data_out_valid_o), 32'(e_valid));
    check("almost_full", 32'(almost_full_o), 32'(n >= AF_TH));
    check("almost_empty", 32'(almost_empty_o), 32'(n <= AE_TH));
    if (e_valid) check("data_o", 32'(data_o), 32'(e_data));
  endtask

  // One clock cycle: drive, compare, clock, update model. One line per transaction.
  task automatic step(input logic clr, input logic vin, input logic [DW-1:0] din, input logic rdy,
                      output logic popped, output logic [DW-1:0] pword);
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          pushed;
    int            n;
    clear_i          = clr;
    data_in_valid_i  = vin;
    data_i           = din;
    data_out_ready_i = rdy;
    #1;
    expect_outs(e_valid, e_data);
    n      = model.size();
    popped = e_valid && rdy;
    pword  = e_data;
    pushed = vin && !clr && (n != DEPTH) && !(popped && n == 0);
    @(posedge clk_i);
    if (clr) begin
      model.delete();
    end else begin
      if (popped && n != 0) void'(model.pop_front());
      if (pushed) model.push_back(din);
    end
    $display("[TB] t=%0t clr=%0b push=%0b din=%02h pop=%0b dout=%02h count=%0d",
             $time, clr, pushed, din, popped, pword, model.size());
    #1;
  endtask

  logic          p;
  logic [DW-1:0] w;
  logic          got;
  logic [DW-1:0] first;

  initial begin
    arst_i = 1'b1;
    clear_i = 1'b0;
    data_i = '0;
    data_in_valid_i = 1'b0;
    data_out_ready_i = 1'b0;
    #2;
    // Reset then idle
    check("rst_count", 32'(count_o), 0);
    check("rst_valid", 32'(data_out_valid_o), 0);
    check("rst_ready", 32'(data_in_ready_o), 1);
    check("rst_ae", 32'(almost_empty_o), 1);
    check("rst_af", 32'(almost_full_o), 0);
    @(posedge clk_i); #1;
    arst_i = 1'b0;
    repeat (2) step(0, 0, 8'h00, 0, p, w);

    // Fill with consumer stalled
    step(0, 1, 8'h11, 0, p, w);
    step(0, 1, 8'h22, 0, p, w);
    step(0, 1, 8'h33, 0, p, w);
    check("fill_af_after3", 32'(almost_full_o), 1);
    step(0, 1, 8'h44, 0, p, w);
    check("fill_count4", 32'(count_o), 4);
    check("fill_ready0", 32'(data_in_ready_o), 0);
    step(0, 1, 8'h99, 0, p, w);
    check("fifth_rejected", 32'(count_o), 4);

    // Full with push+pop requested: first pop only, then both
    step(0, 1, 8'h55, 1, p, w);
    check("full_pop_word", 32'(w), 32'h11);
    check("full_pop_count", 32'(count_o), 3);
    step(0, 1, 8'h55, 1, p, w);
    check("pushpop_word", 32'(w), 32'h22);
    check("pushpop_count", 32'(count_o), 3);
    step(0, 0, 8'h00, 1, p, w); check("drain0", 32'(w), 32'h33);
    step(0, 0, 8'h00, 1, p, w); check("drain1", 32'(w), 32'h44);
    step(0, 0, 8'h00, 1, p, w); check("drain2", 32'(w), 32'h55);
    check("drained_count", 32'(count_o), 0);

    // Streaming one push and one pop per cycle
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'(8'h30 + i), 1, p, w);
`ifdef SYNC_FIFO_CTRL_BYPASS_EN
      check("stream_pop", 32'(p), 1);
      check("stream_word", 32'(w), 32'(8'h30 + i));
`else
      if (i > 0) begin
        check("stream_pop", 32'(p), 1);
        check("stream_word", 32'(w), 32'(8'h30 + i - 1));
      end
`endif
      check("stream_count_le1", 32'(count_o <= 1), 1);
    end
    step(0, 0, 8'h00, 1, p, w);
    check("stream_empty", 32'(count_o), 0);

    // Synchronous clear with push and pop requested
    step(0, 1, 8'hC1, 0, p, w);
    step(0, 1, 8'hC2, 0, p, w);
    step(0, 1, 8'hC3, 0, p, w);
    step(1, 1, 8'hEE, 1, p, w);
    check("clear_no_pop", 32'(p), 0);
    clear_i = 1'b0; data_in_valid_i = 1'b0; #1;
    check("clear_count0", 32'(count_o), 0);
    check("clear_valid0", 32'(data_out_valid_o), 0);
    got = 1'b0; first = '0;
    for (int i = 0; i < 3; i++) begin
      step(0, (i == 0), 8'hAA, 1, p, w);
      if (p && !got) begin got = 1'b1; first = w; end
    end
    check("clear_then_aa", 32'({got, first}), 32'({1'b1, 8'hAA}));

    // Asynchronous reset mid-burst with two words held
    step(0, 1, 8'h61, 0, p, w);
    step(0, 1, 8'h62, 0, p, w);
    data_in_valid_i = 1'b0;
    #2;
    arst_i = 1'b1;
    #1;
    model.delete();
    check("arst_count", 32'(count_o), 0);
    check("arst_valid", 32'(data_out_valid_o), 0);
    check("arst_ready", 32'(data_in_ready_o), 1);
    check("arst_ae", 32'(almost_empty_o), 1);
    @(posedge clk_i); #1;
    arst_i = 1'b0;
    got = 1'b0; first = '0;
    for (int i = 0; i < 3; i++) begin
      step(0, (i == 0), 8'h5A, 1, p, w);
      if (p && !got) begin got = 1'b1; first = w; end
    end
    check("arst_then_5a", 32'({got, first}), 32'({1'b1, 8'h5A}));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), 8'($urandom), 1'($urandom), p, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
